// File: rtl/lock_status_ctrl.sv
// Combination-lock status stage: open/fail/lockout FSM, state timer, failure count, 7-seg messages.
// Optional LOCK_ALARM_EN adds an alarm output that blinks during LOCKOUT.
module lock_status_ctrl #(
  parameter int OPEN_CYCLES    = 100_000_000,
  parameter int FAIL_CYCLES    = 50_000_000,
  parameter int LOCKOUT_CYCLES = 500_000_000,
  parameter int MAX_FAILS      = 3,
  parameter int CNT_W          = 32,
  parameter int ALARM_HALF     = 12_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       attempt_valid,
  input  logic [2:0] digit_ok,
  input  logic       relock,
  output logic       unlocked,
  output logic       locked_out,
  output logic [2:0] fail_count,
  output logic [6:0] H1,
  output logic [6:0] H2,
  output logic [6:0] H3,
  output logic [6:0] H4,
  output logic [6:0] H5,
`ifdef LOCK_ALARM_EN
  output logic [6:0] H6,
  output logic       alarm
`else
  output logic [6:0] H6
`endif
);

  typedef enum logic [1:0] {CLOSED, OPEN, FAIL, LOCKOUT} state_t;

  typedef struct packed {
    logic            unlocked;
    logic            locked_out;
    logic [2:0]      fcnt;
    logic [5:0][6:0] seg;   // [5] = H6 (leftmost) .. [0] = H1
  } out_t;

  localparam logic [5:0][6:0] SEG_CLOSED = {7'h39, 7'h38, 7'h3F, 7'h6D, 7'h79, 7'h5E};
  localparam logic [5:0][6:0] SEG_OPEN   = {7'h00, 7'h00, 7'h3F, 7'h73, 7'h79, 7'h54};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tmr, tmr_nxt;
  logic [2:0]       fcnt_nxt;
  logic [3:0]       finc;
  logic             expired;
  out_t             out_q, out_d;

  function automatic logic [6:0] hex7(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd0:    s = 7'h3F;
      3'd1:    s = 7'h06;
      3'd2:    s = 7'h5B;
      3'd3:    s = 7'h4F;
      3'd4:    s = 7'h66;
      3'd5:    s = 7'h6D;
      3'd6:    s = 7'h7D;
      default: s = 7'h07;
    endcase
    return s;
  endfunction

  assign expired = (tmr == '0);
  assign finc    = {1'b0, fail_count} + 4'd1;

  // state register; outputs are registered from next-state values so they move with the state
  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= CLOSED;
      tmr              <= '0;
      out_q.unlocked   <= 1'b0;
      out_q.locked_out <= 1'b0;
      out_q.fcnt       <= 3'd0;
      out_q.seg        <= ~SEG_CLOSED;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      out_q <= out_d;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fail_count;
    tmr_nxt   = expired ? '0 : tmr - 1'b1;
    case (state)
      CLOSED: begin
        tmr_nxt = '0;
        if (attempt_valid) begin
          if (digit_ok == 3'b111) begin
            state_nxt = OPEN;
            fcnt_nxt  = 3'd0;
            tmr_nxt   = CNT_W'(OPEN_CYCLES - 1);
          end else if (finc >= 4'(MAX_FAILS)) begin
            state_nxt = LOCKOUT;
            fcnt_nxt  = 3'(MAX_FAILS);
            tmr_nxt   = CNT_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_nxt = FAIL;
            fcnt_nxt  = finc[2:0];
            tmr_nxt   = CNT_W'(FAIL_CYCLES - 1);
          end
        end
      end
      OPEN: begin
        if (expired || relock) begin
          state_nxt = CLOSED;
          tmr_nxt   = '0;
        end
      end
      FAIL: begin
        if (expired) state_nxt = CLOSED;
      end
      default: begin
        if (expired) begin
          state_nxt = CLOSED;
          fcnt_nxt  = 3'd0;
        end
      end
    endcase
  end

  always_comb begin
    out_d.unlocked   = (state_nxt == OPEN);
    out_d.locked_out = (state_nxt == LOCKOUT);
    out_d.fcnt       = fcnt_nxt;
    case (state_nxt)
      OPEN:    out_d.seg = ~SEG_OPEN;
      FAIL:    out_d.seg = ~{7'h00, 7'h71, 7'h77, 7'h06, 7'h38, hex7(fcnt_nxt)};
      LOCKOUT: out_d.seg = ~{7'h76, 7'h3F, 7'h38, 7'h5E, 7'h00, hex7(fcnt_nxt)};
      default: out_d.seg = ~SEG_CLOSED;
    endcase
  end

  assign unlocked   = out_q.unlocked;
  assign locked_out = out_q.locked_out;
  assign fail_count = out_q.fcnt;
  assign H6 = out_q.seg[5];
  assign H5 = out_q.seg[4];
  assign H4 = out_q.seg[3];
  assign H3 = out_q.seg[2];
  assign H2 = out_q.seg[1];
  assign H1 = out_q.seg[0];

`ifdef LOCK_ALARM_EN
  logic [CNT_W-1:0] acnt;

  // starts high on LOCKOUT entry, then flips each time the half-period counter wraps
  always_ff @(posedge clock) begin
    if (!reset) begin
      alarm <= 1'b0;
      acnt  <= '0;
    end else if (state_nxt == LOCKOUT) begin
      if (state != LOCKOUT) begin
        alarm <= 1'b1;
        acnt  <= CNT_W'(ALARM_HALF - 1);
      end else if (acnt == '0) begin
        alarm <= ~alarm;
        acnt  <= CNT_W'(ALARM_HALF - 1);
      end else begin
        acnt  <= acnt - 1'b1;
      end
    end else begin
      alarm <= 1'b0;
      acnt  <= '0;
    end
  end
`endif

endmodule
